// File: rtl/box_plotter.sv
// box_plotter: rasterises one BOX_W x BOX_H rectangle per start request into a
// VGA pixel-write port. It presents one pixel per clock in raster order, and the
// rectangle is either filled or drawn as an outline only.
module box_plotter #(
    parameter int BOX_W = 8,
    parameter int BOX_H = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       draw_full,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
    localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);

    // A pixel is on the outline when it sits in the first/last column or row.
    function automatic logic on_border(input logic [3:0] cx, input logic [3:0] cy);
        return (cx == 4'd0) || (cx == CX_LAST) || (cy == 4'd0) || (cy == CY_LAST);
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cx_q, cx_d, cy_q, cy_d;
    logic [7:0] base_x_q, base_x_d, base_y_q, base_y_d;
    logic [2:0] colour_q, colour_d;
    logic       fill_q, fill_d;
    logic [7:0] vga_x_q, vga_x_d, vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic [3:0] ncx_s, ncy_s;

    // Next-state logic. The outputs are computed one cycle ahead, so the
    // registered pixel always matches the counter value held in cx_q/cy_q.
    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        colour_d     = colour_q;
        fill_d       = fill_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        plot_d       = plot_q;
        busy_d       = busy_q;
        done_d       = done_q;
        ncx_s        = 4'd0;
        ncy_s        = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_DRAW;
                    base_x_d     = x_in;
                    base_y_d     = y_in;
                    colour_d     = colour_in;
                    fill_d       = draw_full;
                    cx_d         = 4'd0;
                    cy_d         = 4'd0;
                    vga_x_d      = x_in;
                    vga_y_d      = y_in;
                    vga_colour_d = colour_in;
                    // The top-left corner is always on the border.
                    plot_d       = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                end else begin
                    plot_d = 1'b0;
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end
            end
            S_DRAW: begin
                if ((cx_q == CX_LAST) && (cy_q == CY_LAST)) begin
                    state_d = S_DONE;
                    plot_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    if (cx_q == CX_LAST) begin
                        ncx_s = 4'd0;
                        ncy_s = cy_q + 4'd1;
                    end else begin
                        ncx_s = cx_q + 4'd1;
                        ncy_s = cy_q;
                    end
                    cx_d    = ncx_s;
                    cy_d    = ncy_s;
                    // 8-bit sums wrap modulo 256 by design.
                    vga_x_d = base_x_q + {4'd0, ncx_s};
                    vga_y_d = base_y_q + {4'd0, ncy_s};
                    plot_d  = fill_q | on_border(ncx_s, ncy_s);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                plot_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                plot_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and overrides start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cx_q         <= 4'd0;
            cy_q         <= 4'd0;
            base_x_q     <= 8'd0;
            base_y_q     <= 8'd0;
            colour_q     <= 3'd0;
            fill_q       <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 8'd0;
            vga_colour_q <= 3'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            colour_q     <= colour_d;
            fill_q       <= fill_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/box_plotter.md
Name: box_plotter

Overview:
- Consumes one glyph cell request (X, Y, colour, draw_full) from the keystroke-to-grid translator and rasterises it into the VGA adapter's pixel-write port.
- Each request draws one BOX_W x BOX_H rectangle, one pixel per clock, with its top-left corner at (X, Y).
- The rectangle is either filled or outline-only.
- Sits between the translator and the VGA adapter. A start pulse from the control path launches one draw.

Parameters:
- BOX_W, 8, rectangle width in pixels (2..16).
- BOX_H, 7, rectangle height in pixels (2..16).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request strobe, sampled only in IDLE
- x_in  input  8  top-left X of the cell
- y_in  input  8  top-left Y of the cell
- colour_in  input  3  RGB colour of the cell
- draw_full  input  1  1 = filled rectangle, 0 = outline only
- vga_x  output  8  pixel X to the adapter
- vga_y  output  8  pixel Y to the adapter
- vga_colour  output  3  pixel colour to the adapter
- plot  output  1  pixel write enable, one pixel per high cycle
- busy  output  1  high from the first DRAW cycle through DONE
- done  output  1  one-cycle pulse at the end of a draw

Behaviour:
- Interface: single clock domain. Reset is asynchronous and active-high. Reset has priority over every other event, including a start in the same cycle.
- Reset values: state = IDLE; cx = cy = 0; latched base, colour and mode = 0; plot = busy = done = 0; vga_x = vga_y = 0; vga_colour = 0.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - start = 1 at a clock edge latches x_in, y_in, colour_in and draw_full, clears cx and cy, and moves to DRAW.
  - start = 0 stays in IDLE.
  - Input changes while in IDLE have no effect on the outputs.
- DRAW:
  - Each cycle presents one pixel: vga_x = base_x + cx and vga_y = base_y + cy, both 8-bit sums truncated modulo 256 (wrap, no saturation). vga_colour = latched colour.
  - plot = fill OR border, where border = (cx == 0) OR (cx == BOX_W-1) OR (cy == 0) OR (cy == BOX_H-1).
  - Scan order is raster: cx increments every cycle. When cx == BOX_W-1, cx wraps to 0 and cy increments.
  - When cx == BOX_W-1 and cy == BOX_H-1, the next state is DONE.
  - DRAW lasts exactly BOX_W*BOX_H cycles regardless of mode, so latency is deterministic.
- DONE:
  - Lasts exactly one cycle with done = 1 and plot = 0, then returns to IDLE.
- Output timing:
  - The first pixel appears in the cycle immediately after the start edge.
  - done is high BOX_W*BOX_H + 1 cycles after the start edge.
  - plot is 0 in IDLE and in DONE.
- Latched inputs: inputs are latched only at acceptance. Changes to x_in, y_in, colour_in or draw_full during DRAW do not alter the shape or position of the draw in progress.
- start while busy (DRAW or DONE) is ignored and not queued. The earliest next acceptance is the IDLE cycle after DONE.
- Outline mode issues 2*BOX_W + 2*(BOX_H-2) plots per draw; fill mode issues BOX_W*BOX_H.
- vga_x, vga_y and vga_colour hold their last DRAW values in DONE and IDLE. The adapter ignores them while plot = 0.
- Reset mid-draw: outputs clear asynchronously, the partial rectangle is abandoned, and no done pulse is produced.
- Counter widths: cx and cy are 4 bits, sufficient for the parameter range.

Test Plan:
- Fill draw: reset, then start with x_in=20, y_in=30, colour_in=3'b100, draw_full=1. Required: 56 consecutive plot cycles beginning the cycle after start; the first pixel is (20,30) and the last is (27,36), all with colour 100; done pulses once at cycle 57; busy is high for cycles 1..57.
- Outline draw: x_in=29, y_in=38, colour_in=3'b111, draw_full=0. Required: exactly 26 plots. The interior pixel (30,39) is presented with plot=0, the corner (36,44) with plot=1, and the total DRAW duration is still 56 cycles.
- Busy protection: a second start at cycle 10 of a draw carrying different x_in, and input changes mid-draw. Required: coordinates continue from the original base, no second draw follows done, and the state is IDLE after DONE.
- Wrap-around: x_in=252, y_in=250, fill. Required: vga_x sequence 252, 253, 254, 255, 0, 1, 2, 3; the final row has vga_y = 0; no X/Y carry corruption.
- Reset mid-draw: assert reset asynchronously (between clock edges) at cycle 20. Required: plot, busy and done fall to 0 immediately and no done pulse occurs. After release, a fresh start at (20,30) draws correctly from (20,30).
- Back-to-back: start held high continuously. Required: a new draw is accepted every 58 cycles (56 DRAW + 1 DONE + 1 IDLE), and start asserted together with reset is not accepted.
